// File: rtl/mult_pkg.sv
// Shared constants and state encodings for the shift-add multiplier and its
// companion restoring divider.
package mult_pkg;

    localparam int unsigned MULT_N_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } mult_state_e;

    // Companion divider defaults (dividend/divisor width and state width)
    localparam int unsigned DIV_N_DEFAULT  = 6;
    localparam int unsigned DIV_STATE_W    = 2;

endpackage : mult_pkg

// File: rtl/shift_add_dp.sv
// Shift-add multiplier datapath: accumulator A (N+1 bits incl. carry),
// multiplier/low-product register B, multiplicand register C, N+1-bit adder
// and the combined {A,B} right shift.
// Ports:
//   clk, rst        clock, async active-high reset
//   ldA             add C into the accumulator this cycle
//   ldB, ldC        load B from b_in / C from c_in
//   clrA            clear A
//   calc            shift {A,B} right by one after the optional add
//   b_in, c_in      operand inputs (multiplier, multiplicand)
//   B0              LSB of B, tells the controller whether to add
//   prod_c          {A[N-1:0],B} as it will be after the current iteration
module shift_add_dp
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ldA,
    input  logic             ldB,
    input  logic             ldC,
    input  logic             clrA,
    input  logic             calc,
    input  logic [N-1:0]     b_in,
    input  logic [N-1:0]     c_in,
    output logic             B0,
    output logic [2*N-1:0]   prod_c
);

    logic [N:0]   a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [N-1:0] c_q, c_d;
    logic [N:0]   addend_c;
    logic [N:0]   sum_c;
    logic [2*N:0] shift_c;

    // Adder and combined shift; carry lands in A[N] before the shift
    always_comb begin
        addend_c = ldA ? {1'b0, c_q} : (N+1)'(0);
        sum_c    = a_q + addend_c;
        shift_c  = {sum_c, b_q} >> 1;

        a_d = a_q;
        b_d = b_q;
        c_d = c_q;

        if (clrA) begin
            a_d = '0;
        end else if (calc) begin
            a_d = shift_c[2*N:N];
        end else if (ldA) begin
            a_d = sum_c;
        end

        if (ldB) begin
            b_d = b_in;
        end else if (calc) begin
            b_d = shift_c[N-1:0];
        end

        if (ldC) begin
            c_d = c_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign B0     = b_q[0];
    assign prod_c = shift_c[2*N-1:0];

endmodule : shift_add_dp

// File: rtl/shift_add_mult.sv
// Sequential unsigned N x N shift-add multiplier: controller FSM, iteration
// counter and operand holding registers around shift_add_dp.
// Ports:
//   clk, rst       clock, async active-high reset
//   start          begin a multiplication (sampled in IDLE only)
//   Multiplicand   N-bit unsigned operand, captured on accept
//   Multiplier     N-bit unsigned operand, captured on accept
//   Product        2N-bit registered result, updated only on completion
//   busy           registered, follows LOAD/CALC one cycle later
//   done           registered single-cycle completion pulse
module shift_add_mult
    import mult_pkg::*;
#(
    parameter int unsigned N = MULT_N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     Multiplicand,
    input  logic [N-1:0]     Multiplier,
    output logic [2*N-1:0]   Product,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(N + 1);

    mult_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       mcand_q, mcand_d;
    logic [N-1:0]       mplier_q, mplier_d;
    logic [2*N-1:0]     product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               ld_a_c, ld_b_c, ld_c_c, clr_a_c, calc_c;
    logic               b0_c;
    logic [2*N-1:0]     prod_c;

    shift_add_dp #(.N(N)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .ldA    (ld_a_c),
        .ldB    (ld_b_c),
        .ldC    (ld_c_c),
        .clrA   (clr_a_c),
        .calc   (calc_c),
        .b_in   (mplier_q),
        .c_in   (mcand_q),
        .B0     (b0_c),
        .prod_c (prod_c)
    );

    // Next-state, datapath control and registered-output decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;
        ld_a_c    = 1'b0;
        ld_b_c    = 1'b0;
        ld_c_c    = 1'b0;
        clr_a_c   = 1'b0;
        calc_c    = 1'b0;
        // Status flags trail the state by one cycle
        busy_d    = (state_q == LOAD) || (state_q == CALC);
        done_d    = (state_q == DONE);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = Multiplicand;
                    mplier_d = Multiplier;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                clr_a_c = 1'b1;
                ld_b_c  = 1'b1;
                ld_c_c  = 1'b1;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                ld_a_c = b0_c;
                calc_c = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Last iteration: capture the post-shift product directly
                if (cnt_q == CNT_W'(N - 1)) begin
                    product_d = prod_c;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule : shift_add_mult

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult (N=6): directed cases, reset abort,
// back-to-back start, and a random sweep against an arithmetic model.
module tb_shift_add_mult;

    localparam int unsigned N   = 6;
    localparam int unsigned LAT = N + 2;   // accept edge -> done visible
    localparam int unsigned PER = N + 3;   // accept-to-accept with start held

    logic             clk;
    logic             rst;
    logic             start;
    logic [N-1:0]     mcand;
    logic [N-1:0]     mplier;
    logic [2*N-1:0]   product;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;
    logic done_prev;

    shift_add_mult #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .Multiplicand (mcand),
        .Multiplier   (mplier),
        .Product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // done must never be high on two consecutive cycles
    always @(negedge clk) begin
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (done) check_eq("done_single", 64'(done_prev), 64'd0);
            done_prev = done;
        end
    end

    // Called at a negedge with the DUT idle; checks timing, hold and result.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [63:0] prev;
        logic [63:0] exp;
        int          lat;
        bit          got;
        prev   = 64'(product);
        exp    = 64'(a) * 64'(b);
        start  = 1'b1;
        mcand  = a;
        mplier = b;
        @(negedge clk);
        start  = 1'b0;
        mcand  = N'($urandom);
        mplier = N'($urandom);
        lat    = 0;
        got    = 1'b0;
        while (!got && lat <= 40) begin
            check_eq("busy", 64'(busy), 64'(lat >= 1 && lat <= int'(N + 1)));
            check_eq("done_timing", 64'(done), 64'(lat == int'(LAT)));
            if (lat <= int'(N)) check_eq("product_hold", 64'(product), prev);
            if (done) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check_eq("latency", 64'(lat), 64'(LAT));
        check_eq("product", 64'(product), exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] qa[$];
        logic [N-1:0] qb[$];
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        mcand     = '0;
        mplier    = '0;
        done_prev = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst_product", 64'(product), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        rst = 1'b0;

        run_op(6'd5, 6'd3);
        run_op(6'd0, 6'd45);
        run_op(6'd45, 6'd0);
        run_op(6'd63, 6'd63);

        // Reset during CALC of 7*9 abandons the operation
        start  = 1'b1;
        mcand  = 6'd7;
        mplier = 6'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("midrst_product", 64'(product), 64'd0);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(N + 4); i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", 64'(done), 64'd0);
            check_eq("midrst_prod0", 64'(product), 64'd0);
        end
        run_op(6'd7, 6'd9);

        // start held high with operands changing every cycle
        for (int t = 0; t <= int'(3 * PER); t++) begin
            if (t > 0) begin
                int  e;
                bit  exp_done;
                e        = t - 1;
                exp_done = (e >= int'(LAT)) && (((e - int'(LAT)) % int'(PER)) == 0);
                check_eq("cont_done", 64'(done), 64'(exp_done));
                if (exp_done) begin
                    int idx;
                    idx = e - int'(LAT);
                    check_eq("cont_product", 64'(product), 64'(qa[idx]) * 64'(qb[idx]));
                end
            end
            mcand  = N'($urandom);
            mplier = N'($urandom);
            qa.push_back(mcand);
            qb.push_back(mplier);
            start  = (t < int'(3 * PER));
            @(negedge clk);
        end
        start = 1'b0;

        // Random sweep
        for (int i = 0; i < 1000; i++) begin
            run_op(N'($urandom), N'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_shift_add_mult
